// File: rtl/cpu_run_controller_pkg.sv
// Shared types and defaults for the core run controller.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_RUN,
        ST_PAUSED,
        ST_HALTED
    } run_state_t;

    localparam logic [31:0] HALT_WORD_DEF      = 32'h0000_0000;
    localparam int          RESET_CYCLES_DEF   = 2;
    localparam int          TIMEOUT_CYCLES_DEF = 100000;

    // Width of the reset-hold down-counter, which is loaded with cycles-1.
    function automatic int hold_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// Host/core-facing signal bundle of the run controller.
// master = host/core side, slave = controller side.
interface cpu_run_controller_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int COUNT_WIDTH = 32
);
    logic                   start;
    logic                   stop;
    logic                   step;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [INSTR_WIDTH-1:0] pc;
    logic                   core_reset;
    logic                   core_enable;
    logic                   running;
    logic                   halted;
    logic                   timeout;
    logic [INSTR_WIDTH-1:0] halt_pc;
    logic [COUNT_WIDTH-1:0] cycle_count;

    modport master (
        output start, stop, step, instruction, pc,
        input  core_reset, core_enable, running, halted, timeout, halt_pc, cycle_count
    );

    modport slave (
        input  start, stop, step, instruction, pc,
        output core_reset, core_enable, running, halted, timeout, halt_pc, cycle_count
    );
endinterface

// File: rtl/cpu_run_controller_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_value,
    output logic             o_at_max
);

    logic [WIDTH-1:0] r_value;

    // Count enabled cycles; clear has priority over increment.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clr) begin
            r_value <= '0;
        end else if (i_inc && !o_at_max) begin
            r_value <= r_value + WIDTH'(1);
        end
    end

    assign o_value  = r_value;
    assign o_at_max = &r_value;

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle core: reset sequencing, clock-enable
// gating for run/pause/step, halt-word detection and a runaway watchdog.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | core held in reset, waiting for start
//   ST_RST_HOLD | core reset held for RESET_CYCLES cycles
//   ST_RUN      | free-running, one instruction per cycle
//   ST_PAUSED   | frozen; step executes exactly one instruction
//   ST_HALTED   | halt word or watchdog hit; core state kept for inspection
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int                     INSTR_WIDTH    = 32,
    parameter int                     COUNT_WIDTH    = 32,
    parameter int                     RESET_CYCLES   = RESET_CYCLES_DEF,
    parameter int                     TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD      = INSTR_WIDTH'(HALT_WORD_DEF)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    cpu_run_controller_if.slave  bus
);

    localparam int          HOLD_W    = hold_width(RESET_CYCLES);
    localparam logic [63:0] TIMEOUT_W = 64'(TIMEOUT_CYCLES);

    run_state_t             r_state;
    logic [HOLD_W-1:0]      r_hold;
    logic                   r_running;
    logic                   r_halted;
    logic                   r_timeout;
    logic [INSTR_WIDTH-1:0] r_halt_pc;

    logic                   w_is_halt;
    logic                   w_restart;
    logic                   w_core_enable;
    logic                   w_core_reset;
    logic                   w_wd_hit;
    logic                   w_at_max;
    logic [COUNT_WIDTH-1:0] w_count;
    logic [COUNT_WIDTH-1:0] w_count_next;

    assign w_is_halt = (bus.instruction == HALT_WORD);

    // A start from IDLE or HALTED is a full restart; from PAUSED it only resumes.
    assign w_restart = bus.start && ((r_state == ST_IDLE) || (r_state == ST_HALTED));

    // The watchdog looks at the count this enabled cycle produces, so the
    // cycle that reaches the limit still executes and its PC is captured.
    assign w_count_next = w_at_max ? w_count : w_count + COUNT_WIDTH'(1);
    assign w_wd_hit     = (TIMEOUT_CYCLES != 0) && w_core_enable
                          && (64'(w_count_next) == TIMEOUT_W);

    // Core reset/enable decode; controller reset forces the core into reset at once.
    always_comb begin
        w_core_enable = 1'b0;
        w_core_reset  = i_reset;
        case (r_state)
            ST_IDLE,
            ST_RST_HOLD: w_core_reset  = 1'b1;
            ST_RUN:      w_core_enable = !w_is_halt && !bus.stop;
            ST_PAUSED:   w_core_enable = bus.step && !w_is_halt;
            default:     w_core_enable = 1'b0;
        endcase
        if (i_reset) begin
            w_core_enable = 1'b0;
        end
    end

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cycle_cnt (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_inc    (w_core_enable),
        .i_clr    (w_restart),
        .o_value  (w_count),
        .o_at_max (w_at_max)
    );

    // State machine with registered status outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_hold    <= '0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
            r_halt_pc <= '0;
        end else begin
            case (r_state)
                ST_IDLE,
                ST_HALTED: begin
                    if (bus.start) begin
                        r_state   <= ST_RST_HOLD;
                        r_hold    <= HOLD_W'(RESET_CYCLES - 1);
                        r_running <= 1'b0;
                        r_halted  <= 1'b0;
                        r_timeout <= 1'b0;
                        r_halt_pc <= '0;
                    end
                end
                ST_RST_HOLD: begin
                    if (r_hold == '0) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_is_halt) begin
                        r_state   <= ST_HALTED;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                        r_halt_pc <= bus.pc;
                    end else if (w_wd_hit) begin
                        r_state   <= ST_HALTED;
                        r_running <= 1'b0;
                        r_halted  <= 1'b1;
                        r_timeout <= 1'b1;
                        r_halt_pc <= bus.pc;
                    end else if (bus.stop) begin
                        r_state   <= ST_PAUSED;
                        r_running <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (bus.step && w_is_halt) begin
                        r_state   <= ST_HALTED;
                        r_halted  <= 1'b1;
                        r_halt_pc <= bus.pc;
                    end else if (w_wd_hit) begin
                        r_state   <= ST_HALTED;
                        r_halted  <= 1'b1;
                        r_timeout <= 1'b1;
                        r_halt_pc <= bus.pc;
                    end else if (bus.start) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_reset  = w_core_reset;
    assign bus.core_enable = w_core_enable;
    assign bus.running     = r_running;
    assign bus.halted      = r_halted;
    assign bus.timeout     = r_timeout;
    assign bus.halt_pc     = r_halt_pc;
    assign bus.cycle_count = w_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: three instances (default, short
// watchdog, 3-bit saturating count), each driving a tiny PC/memory core model.
module tb_cpu_run_controller;

    logic clk;
    logic rst0, rst1, rst2;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    logic [31:0] mem2 [64];
    logic [31:0] pc0, pc1, pc2;

    cpu_run_controller_if #(.INSTR_WIDTH(32), .COUNT_WIDTH(32)) if0 ();
    cpu_run_controller_if #(.INSTR_WIDTH(32), .COUNT_WIDTH(32)) if1 ();
    cpu_run_controller_if #(.INSTR_WIDTH(32), .COUNT_WIDTH(3))  if2 ();

    cpu_run_controller #(.INSTR_WIDTH(32), .COUNT_WIDTH(32)) u_dut0 (
        .i_clock (clk), .i_reset (rst0), .bus (if0.slave));
    cpu_run_controller #(.INSTR_WIDTH(32), .COUNT_WIDTH(32), .TIMEOUT_CYCLES(8)) u_dut1 (
        .i_clock (clk), .i_reset (rst1), .bus (if1.slave));
    cpu_run_controller #(.INSTR_WIDTH(32), .COUNT_WIDTH(3), .TIMEOUT_CYCLES(0)) u_dut2 (
        .i_clock (clk), .i_reset (rst2), .bus (if2.slave));

    assign if0.pc = pc0;
    assign if1.pc = pc1;
    assign if2.pc = pc2;
    assign if0.instruction = mem0[pc0[7:2]];
    assign if1.instruction = mem1[pc1[7:2]];
    assign if2.instruction = mem2[pc2[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: PC resets with core_reset and advances one word per enabled cycle.
    always @(posedge clk) begin
        pc0 <= if0.core_reset ? 32'd0 : (if0.core_enable ? pc0 + 32'd4 : pc0);
        pc1 <= if1.core_reset ? 32'd0 : (if1.core_enable ? pc1 + 32'd4 : pc1);
        pc2 <= if2.core_reset ? 32'd0 : (if2.core_enable ? pc2 + 32'd4 : pc2);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // The halt word must never be executed, whatever state or inputs.
    always begin
        @(negedge clk);
        #2;
        if (if0.instruction == 32'd0 && !rst0) check_val("en_on_halt0", 32'(if0.core_enable), 32'd0);
        if (if2.instruction == 32'd0 && !rst2) check_val("en_on_halt2", 32'(if2.core_enable), 32'd0);
    end

    function automatic logic get_flag(input int which, input bit want_halt);
        case (which)
            0:       return want_halt ? if0.halted : if0.running;
            1:       return want_halt ? if1.halted : if1.running;
            default: return want_halt ? if2.halted : if2.running;
        endcase
    endfunction

    task automatic wait_flag(input int which, input bit want_halt, input int budget, input string tag);
        int   n;
        logic f;
        n = 0;
        f = 1'b0;
        while (!f && n < budget) begin
            @(negedge clk);
            n++;
            f = get_flag(which, want_halt);
        end
        check_val(tag, 32'(f), 32'd1);
    endtask

    task automatic pulse_start(input int which);
        @(negedge clk);
        case (which)
            0:       if0.start = 1'b1;
            1:       if1.start = 1'b1;
            default: if2.start = 1'b1;
        endcase
        @(negedge clk);
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int en_cnt;
        if0.start = 0; if0.stop = 0; if0.step = 0;
        if1.start = 0; if1.stop = 0; if1.step = 0;
        if2.start = 0; if2.stop = 0; if2.step = 0;
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 32'(i + 1);
            mem1[i] = 32'h13;
            mem2[i] = 32'h13;
        end
        mem0[5]  = 32'd0;
        mem2[10] = 32'd0;
        rst0 = 1; rst1 = 1; rst2 = 1;
        repeat (2) @(negedge clk);
        rst0 = 0; rst1 = 0; rst2 = 0;

        // Reset values
        check_val("rst_core_reset", 32'(if0.core_reset), 32'd1);
        check_val("rst_core_enable", 32'(if0.core_enable), 32'd0);
        check_val("rst_running", 32'(if0.running), 32'd0);
        check_val("rst_halted", 32'(if0.halted), 32'd0);
        check_val("rst_timeout", 32'(if0.timeout), 32'd0);
        check_val("rst_halt_pc", if0.halt_pc, 32'd0);
        check_val("rst_count", if0.cycle_count, 32'd0);

        // Test 1: five instructions then the halt word
        pulse_start(0);
        n = 0;
        while (if0.core_reset && n < 10) begin
            n++;
            @(negedge clk);
        end
        check_val("t1_reset_cycles", 32'(n), 32'd2);
        wait_flag(0, 1'b1, 30, "t1_wait_halt");
        check_val("t1_count", if0.cycle_count, 32'd5);
        check_val("t1_halt_pc", if0.halt_pc, 32'h14);
        check_val("t1_timeout", 32'(if0.timeout), 32'd0);
        check_val("t1_running", 32'(if0.running), 32'd0);

        // Test 2: stop at count 3, two steps, resume
        mem0[5] = 32'd6;
        pulse_start(0);
        wait_flag(0, 1'b0, 10, "t2_wait_run");
        check_val("t2_count_run0", if0.cycle_count, 32'd0);
        repeat (3) @(negedge clk);
        check_val("t2_count3", if0.cycle_count, 32'd3);
        if0.stop = 1'b1;
        #1 check_val("t2_en_stop", 32'(if0.core_enable), 32'd0);
        @(negedge clk);
        if0.stop = 1'b0;
        check_val("t2_paused_run", 32'(if0.running), 32'd0);
        check_val("t2_paused_halt", 32'(if0.halted), 32'd0);
        check_val("t2_paused_cnt", if0.cycle_count, 32'd3);
        @(negedge clk);
        check_val("t2_paused_hold", if0.cycle_count, 32'd3);
        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if0.step = (i == 1 || i == 3);
            #1;
            if (if0.core_enable) en_cnt++;
        end
        @(negedge clk);
        check_val("t2_step_enables", 32'(en_cnt), 32'd2);
        check_val("t2_step_count", if0.cycle_count, 32'd5);
        check_val("t2_still_paused", 32'(if0.running), 32'd0);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        check_val("t2_resumed", 32'(if0.running), 32'd1);
        check_val("t2_resume_cnt", if0.cycle_count, 32'd5);
        @(negedge clk);
        check_val("t2_run_cnt", if0.cycle_count, 32'd6);

        // Test 4a: stop and halt word in the same RUN cycle
        mem0[6] = 32'd0;
        if0.stop = 1'b1;
        #1 check_val("t4_en_stop_halt", 32'(if0.core_enable), 32'd0);
        @(negedge clk);
        if0.stop = 1'b0;
        check_val("t4_halted", 32'(if0.halted), 32'd1);
        check_val("t4_not_running", 32'(if0.running), 32'd0);
        check_val("t4_halt_pc", if0.halt_pc, 32'h18);
        check_val("t4_count", if0.cycle_count, 32'd6);
        mem0[6] = 32'd7;

        // Test 4b: step onto the halt word while paused
        pulse_start(0);
        wait_flag(0, 1'b0, 10, "t4b_wait_run");
        @(negedge clk);
        if0.stop = 1'b1;
        @(negedge clk);
        if0.stop = 1'b0;
        check_val("t4b_paused_cnt", if0.cycle_count, 32'd1);
        mem0[1] = 32'd0;
        if0.step = 1'b1;
        #1 check_val("t4b_en_step_halt", 32'(if0.core_enable), 32'd0);
        @(negedge clk);
        if0.step = 1'b0;
        check_val("t4b_halted", 32'(if0.halted), 32'd1);
        check_val("t4b_halt_pc", if0.halt_pc, 32'h4);
        check_val("t4b_count", if0.cycle_count, 32'd1);
        check_val("t4b_timeout", 32'(if0.timeout), 32'd0);
        mem0[1] = 32'd2;

        // Test 5: controller reset mid-run
        pulse_start(0);
        wait_flag(0, 1'b0, 10, "t5_wait_run");
        repeat (4) @(negedge clk);
        check_val("t5_count4", if0.cycle_count, 32'd4);
        rst0 = 1'b1;
        #1;
        check_val("t5_core_reset_now", 32'(if0.core_reset), 32'd1);
        check_val("t5_enable_now", 32'(if0.core_enable), 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        check_val("t5_core_reset", 32'(if0.core_reset), 32'd1);
        check_val("t5_running", 32'(if0.running), 32'd0);
        check_val("t5_halted", 32'(if0.halted), 32'd0);
        check_val("t5_timeout", 32'(if0.timeout), 32'd0);
        check_val("t5_halt_pc", if0.halt_pc, 32'd0);
        check_val("t5_count", if0.cycle_count, 32'd0);
        pulse_start(0);
        wait_flag(0, 1'b0, 10, "t5_wait_rerun");
        check_val("t5_rerun_reset", 32'(if0.core_reset), 32'd0);
        check_val("t5_rerun_cnt0", if0.cycle_count, 32'd0);
        @(negedge clk);
        check_val("t5_rerun_cnt1", if0.cycle_count, 32'd1);

        // Test 3: watchdog at 8 cycles on a program with no halt word
        pulse_start(1);
        wait_flag(1, 1'b1, 40, "t3_wait_halt");
        check_val("t3_timeout", 32'(if1.timeout), 32'd1);
        check_val("t3_count", if1.cycle_count, 32'd8);
        check_val("t3_halt_pc", if1.halt_pc, 32'h1C);
        check_val("t3_running", 32'(if1.running), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("t3_en_after", 32'(if1.core_enable), 32'd0);
        end
        check_val("t3_count_after", if1.cycle_count, 32'd8);

        // Test 6: 3-bit count saturates over 10 enabled cycles
        pulse_start(2);
        wait_flag(2, 1'b1, 60, "t6_wait_halt");
        check_val("t6_count_sat", 32'(if2.cycle_count), 32'd7);
        check_val("t6_halt_pc", if2.halt_pc, 32'h28);
        check_val("t6_timeout", 32'(if2.timeout), 32'd0);
        pulse_start(2);
        check_val("t6_count_clr", 32'(if2.cycle_count), 32'd0);
        check_val("t6_halted_clr", 32'(if2.halted), 32'd0);
        check_val("t6_core_reset", 32'(if2.core_reset), 32'd1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
